if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage between the program-counter register and the decode stage. Takes the current PC, issues a request to variable-latency instruction memory and waits for the acknowledge. It then writes the instruction, PC and PC+4 into the IF/ID pipeline register and drives the PC hold control. It absorbs decode stalls with a one-entry holding buffer and kills in-flight fetches on branch/jump flush.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
DATA_W, 32, instruction width
NOP, 32'h0000_0000, instruction inserted as a bubble

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
pc_in  in  ADDR_W  current PC (PC register output)
stall  in  1  decode hazard; IF/ID must hold
flush  in  1  taken branch/jump; kill fetch, PC loads target this cycle
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_W  fetch address, registered, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  DATA_W  fetched instruction
pc_hold  out  1  to PC enable; 1=hold, 0=load next PC (combinational)
if_valid  out  1  IF/ID holds a real instruction
if_instr  out  DATA_W  IF/ID instruction
if_pc  out  ADDR_W  IF/ID PC of the instruction
if_pc4  out  ADDR_W  IF/ID PC+4, modulo 2^ADDR_W

Behaviour:
- Reset (async, any state): state=IDLE; imem_req=0; imem_addr=0; if_valid=0; if_instr=NOP; if_pc=0; if_pc4=0; hold_buf=NOP; pc_hold forced 1 while reset is high.
- States: IDLE, WAIT, DROP, HOLD.
- IDLE:
  - flush=0: imem_req<=1, imem_addr<=pc_in, go to WAIT.
  - flush=1: stay in IDLE; no request.
- WAIT: imem_req stays 1 until ack; imem_addr is unchanged. On the ack cycle:
  - flush=1: discard data, go to IDLE.
  - stall=1: hold_buf<=imem_rdata, go to HOLD.
  - otherwise (deliver): load IF/ID from imem_rdata and imem_addr, go to IDLE.
  - In all three cases imem_req<=0.
  - If flush=1 with no ack: go to DROP. Memory cannot cancel, so imem_req stays 1.
- DROP: on ack, discard data, imem_req<=0, go to IDLE. A flush here is accepted but changes nothing further.
- HOLD: imem_req=0.
  - flush=1: discard hold_buf, go to IDLE.
  - stall=0 (deliver): load IF/ID from hold_buf and imem_addr, go to IDLE.
- deliver = (WAIT & imem_ack | HOLD) & ~stall & ~flush.
- pc_hold = reset | ~(deliver | flush).
- IF/ID update priority:
  - flush: if_valid<=0, if_instr<=NOP. if_pc and if_pc4 hold.
  - else stall: all IF/ID outputs hold.
  - else deliver: if_valid<=1, if_instr<=data, if_pc<=imem_addr, if_pc4<=imem_addr+4.
  - else: bubble, if_valid<=0, if_instr<=NOP.
- Throughput: best case one instruction every 2 cycles (ack the cycle after request). Latency from PC change to IF/ID valid = 1 + ack wait + 1 cycles.
- PC+4 wraps: 0xFFFF_FFFC -> if_pc4=0x0000_0000.
- imem_ack outside WAIT/DROP is ignored.
- Reset mid-fetch abandons the request. A late ack after reset is ignored (state is IDLE).

Test Plan:
- Zero-wait fetch: memory acks the cycle after req, returns 0x2000_0001 at 0x0 and 0x2000_0002 at 0x4, no stall or flush, PC stepping by 4 on pc_hold=0 -> if_valid pulses every 2nd cycle with if_instr 0x2000_0001 (if_pc=0x0, if_pc4=0x4), then 0x2000_0002 (if_pc=0x4, if_pc4=0x8). pc_hold=0 exactly on the ack cycles.
- 3-cycle ack latency at pc_in=0x100 -> imem_req=1 and imem_addr=0x100 for 3 cycles, pc_hold=1 throughout, IF/ID loaded on the ack edge.
- stall=1 when ack arrives with 0xDEAD_BEEF, stall held 4 cycles -> state HOLD, IF/ID outputs unchanged, pc_hold=1. On stall release: if_instr=0xDEAD_BEEF, if_valid=1, pc_hold=0 for one cycle.
- flush=1 in WAIT before ack, ack 2 cycles later with 0x1234_5678 -> DROP, data never reaches IF/ID, if_valid=0. The next request uses the new pc_in (branch target 0x400).
- flush and stall both 1 on the ack cycle -> data discarded, if_valid=0, if_instr=NOP, pc_hold=0, state IDLE.
- reset asserted asynchronously mid-WAIT, ack arrives during reset -> all outputs at reset values immediately. After release, fetch restarts from pc_in with imem_req=1 one cycle later. pc_in=0xFFFF_FFFC gives if_pc4=0x0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: takes the PC, issues a request to variable-latency
// instruction memory, waits for the acknowledge, and loads the IF/ID pipeline
// register. A one-entry holding buffer absorbs decode stalls. Branch/jump
// flushes kill the fetch in flight.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   pc_in                  current PC from the PC register
//   stall                  decode hazard, IF/ID must hold
//   flush                  taken branch/jump, PC loads its target this cycle
//   imem_req, imem_addr    registered fetch request and address
//   imem_ack, imem_rdata   one-cycle acknowledge with the instruction
//   pc_hold                combinational PC enable (1 = hold, 0 = load next PC)
//   if_valid, if_instr     IF/ID valid flag and instruction
//   if_pc, if_pc4          IF/ID PC and PC+4 (modulo 2^ADDR_W)
module if_fetch_stage #(
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              pc_hold,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] hold_buf_q, hold_buf_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    logic              deliver_c;
    logic [DATA_W-1:0] fetch_data_c;

    // An instruction leaves the stage when it is fresh from memory or buffered,
    // and decode is neither stalled nor flushed.
    assign deliver_c    = ((state_q == WAIT && imem_ack) || state_q == HOLD)
                          && !stall && !flush;
    assign fetch_data_c = (state_q == HOLD) ? hold_buf_q : imem_rdata;

    // The PC advances on a delivery or loads the branch target on a flush.
    assign pc_hold = reset | ~(deliver_c | flush);

    // State register and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            hold_buf_q <= NOP;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            pc_q       <= '0;
            pc4_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            hold_buf_q <= hold_buf_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
        end
    end

    // Next-state, memory request and IF/ID update.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        hold_buf_d = hold_buf_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    req_d   = 1'b1;
                    addr_d  = pc_in;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else if (stall) begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    // Memory cannot cancel; keep requesting and drop the reply.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    hold_buf_d = NOP;
                    state_d    = IDLE;
                end else if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // IF/ID: flush beats stall beats delivery; otherwise insert a bubble.
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (!stall) begin
            if (deliver_c) begin
                valid_d = 1'b1;
                instr_d = fetch_data_c;
                pc_d    = addr_q;
                pc4_d   = addr_q + PC_STEP;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = pc_q;
    assign if_pc4    = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_hold;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    if_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_hold    (pc_hold),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: outstanding memory transaction, stall buffer, IF/ID.
    logic        m_req;       // a request is outstanding at memory
    logic        m_kill;      // its reply must be thrown away
    logic [31:0] m_addr;      // address of the most recent request
    logic        m_buf_full;  // fetched instruction parked during a stall
    logic [31:0] m_buf;
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_pc4;

    logic [31:0] pc;          // the PC register the stage controls
    logic [31:0] br_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_kill = 1'b0; m_addr = '0;
        m_buf_full = 1'b0; m_buf = NOP;
        m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_pc4 = '0;
    endtask

    // One clock of the model; returns the expected pc_hold for this cycle.
    task automatic model_cycle(input logic st, input logic fl, input logic ak,
                               input logic [31:0] rd, input logic [31:0] pcv,
                               output logic hold_o);
        logic        idle, fetched, deliver;
        logic [31:0] data;
        idle    = !m_req && !m_buf_full;
        fetched = m_req && !m_kill && ak;
        deliver = (fetched || m_buf_full) && !st && !fl;
        data    = m_buf_full ? m_buf : rd;
        hold_o  = !(deliver || fl);

        if (fl) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (!st) begin
            if (deliver) begin
                m_valid = 1'b1; m_instr = data;
                m_pc = m_addr; m_pc4 = m_addr + 32'd4;
            end else begin
                m_valid = 1'b0; m_instr = NOP;
            end
        end

        if (idle) begin
            if (!fl) begin
                m_req = 1'b1; m_addr = pcv; m_kill = 1'b0;
            end
        end else if (m_req) begin
            if (ak) begin
                m_req = 1'b0;
                if (!m_kill && !fl && st) begin
                    m_buf_full = 1'b1; m_buf = rd;
                end
            end else if (fl) begin
                m_kill = 1'b1;
            end
        end else if (fl || !st) begin
            m_buf_full = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".imem_req"},  32'(imem_req), 32'(m_req));
        chk({tag, ".imem_addr"}, imem_addr,     m_addr);
        chk({tag, ".if_valid"},  32'(if_valid), 32'(m_valid));
        chk({tag, ".if_instr"},  if_instr,      m_instr);
        chk({tag, ".if_pc"},     if_pc,         m_pc);
        chk({tag, ".if_pc4"},    if_pc4,        m_pc4);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".imem_req"},  32'(imem_req), 32'd0);
        chk({tag, ".imem_addr"}, imem_addr,     32'd0);
        chk({tag, ".if_valid"},  32'(if_valid), 32'd0);
        chk({tag, ".if_instr"},  if_instr,      NOP);
        chk({tag, ".if_pc"},     if_pc,         32'd0);
        chk({tag, ".if_pc4"},    if_pc4,        32'd0);
        chk({tag, ".pc_hold"},   32'(pc_hold),  32'd1);
    endtask

    // Called just after a rising edge: apply inputs, check pc_hold, clock,
    // then check the registered outputs.
    task automatic step(input string tag, input logic st, input logic fl,
                        input logic ak, input logic [31:0] rd);
        logic exp_hold;
        stall = st; flush = fl; imem_ack = ak; imem_rdata = rd; pc_in = pc;
        #1;
        model_cycle(st, fl, ak, rd, pc, exp_hold);
        chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(exp_hold));
        if (!exp_hold) pc = fl ? br_target : pc + 32'd4;
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        int          wait_left;
        logic        was_req, ak, st, fl;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; pc_in = '0; pc = '0; br_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Zero-wait fetch of two instructions.
        step("zw_req0", 0, 0, 0, 32'hAAAA_AAAA);
        chk("zw_addr0", imem_addr, 32'h0);
        step("zw_ack0", 0, 0, 1, 32'h2000_0001);
        chk("zw_instr0", if_instr, 32'h2000_0001);
        chk("zw_pc4_0", if_pc4, 32'h4);
        step("zw_req1", 0, 0, 0, 32'hBBBB_BBBB);
        chk("zw_bubble", 32'(if_valid), 32'd0);
        step("zw_ack1", 0, 0, 1, 32'h2000_0002);
        chk("zw_instr1", if_instr, 32'h2000_0002);
        chk("zw_pc1", if_pc, 32'h4);
        chk("zw_pc4_1", if_pc4, 32'h8);

        // Three-cycle acknowledge latency at 0x100.
        pc = 32'h100;
        step("lat_req", 0, 0, 0, 32'h0);
        step("lat_w1",  0, 0, 0, 32'h0);
        step("lat_w2",  0, 0, 0, 32'h0);
        chk("lat_addr", imem_addr, 32'h100);
        step("lat_ack", 0, 0, 1, 32'h0300_0013);
        chk("lat_pc", if_pc, 32'h100);

        // Stall on the acknowledge, held for four cycles.
        step("st_req", 0, 0, 0, 32'h0);
        step("st_ack", 1, 0, 1, 32'hDEAD_BEEF);
        step("st_h1",  1, 0, 0, 32'h0);
        step("st_h2",  1, 0, 0, 32'h0);
        step("st_h3",  1, 0, 0, 32'h0);
        step("st_rel", 0, 0, 0, 32'h0);
        chk("st_instr", if_instr, 32'hDEAD_BEEF);
        chk("st_valid", 32'(if_valid), 32'd1);

        // Flush before the acknowledge; reply must be dropped.
        br_target = 32'h400;
        step("fl_req",  0, 0, 0, 32'h0);
        step("fl_kill", 0, 1, 0, 32'h0);
        step("fl_w",    0, 0, 0, 32'h0);
        step("fl_ack",  0, 0, 1, 32'h1234_5678);
        chk("fl_valid", 32'(if_valid), 32'd0);
        step("fl_req2", 0, 0, 0, 32'h0);
        chk("fl_target", imem_addr, 32'h400);
        step("fl_ack2", 0, 0, 1, 32'h0000_0093);

        // Flush and stall together on the acknowledge.
        br_target = 32'h800;
        step("fs_req", 0, 0, 0, 32'h0);
        step("fs_ack", 1, 1, 1, 32'h5555_5555);
        chk("fs_instr", if_instr, NOP);
        step("fs_next", 0, 0, 0, 32'h0);
        chk("fs_addr", imem_addr, 32'h800);
        step("fs_ack2", 0, 0, 1, 32'h0000_0113);

        // Asynchronous reset mid-WAIT with a late acknowledge.
        step("rs_req", 0, 0, 0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rs_async");
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check_reset_vals("rs_held");
        reset = 1'b0;
        model_reset();
        pc = 32'hFFFF_FFFC;
        step("wr_req", 0, 0, 0, 32'h0);
        chk("wr_req1", 32'(imem_req), 32'd1);
        step("wr_ack", 0, 0, 1, 32'hCAFE_0001);
        chk("wr_pc4", if_pc4, 32'h0);

        // Random traffic: variable latency, stalls, flushes, stray acks.
        wait_left = 0;
        for (int i = 0; i < 400; i++) begin
            was_req = m_req;
            if (m_req) begin
                ak = (wait_left == 0);
                if (!ak) wait_left--;
            end else begin
                ak = ($urandom_range(0, 9) == 0);
            end
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            br_target = $urandom & 32'hFFFF_FFFC;
            step("rnd", st, fl, ak, $urandom);
            if (m_req && !was_req) wait_left = $urandom_range(0, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
